// File: rtl/gauss_seq_ctrl_pkg.sv
// rtl/gauss_seq_ctrl_pkg.sv - shared op codes, defaults and state encoding for the Gauss sequencer
package gauss_seq_ctrl_pkg;

   localparam int GF_BIT_DEF      = 4;
   localparam int OP_CODE_LEN_DEF = 4;

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_GAUSS = 4'b0001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_FEED,
      S_FLUSH,
      S_COLLECT,
      S_DONE
   } state_t;

endpackage

// File: rtl/gauss_seq_cnt.sv
// rtl/gauss_seq_cnt.sv - loadable up-counter with terminal-count flag
module gauss_seq_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic [WIDTH-1:0] term_val,
   output logic [WIDTH-1:0] count,
   output logic             term
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign term = (count == term_val);

endmodule

// File: rtl/gauss_seq_ctrl.sv
// rtl/gauss_seq_ctrl.sv - row read/feed/flush/collect sequencer for the Gauss array; GAUSS_SINGULAR_CHECK_EN enables the singular flag
module gauss_seq_ctrl
   import gauss_seq_ctrl_pkg::*;
#(
   parameter int GF_BIT      = GF_BIT_DEF,
   parameter int OP_CODE_LEN = OP_CODE_LEN_DEF,
   parameter int N           = 16,
   parameter int DRAIN       = 2 * N
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_start,
   output logic                        busy,
   output logic                        done,
   output logic                        singular,
   output logic                        mem_rd_en,
   output logic [$clog2(N)-1:0]        mem_rd_addr,
   input  logic [(N+1)*GF_BIT-1:0]     mem_rd_data,
   output logic                        arr_start,
   output logic                        arr_finish,
   output logic                        arr_functionA,
   output logic [OP_CODE_LEN-1:0]      arr_op,
   output logic [(N+1)*GF_BIT-1:0]     arr_data,
   input  logic [(N+1)*GF_BIT-1:0]     arr_res_data,
   input  logic                        pivot_ok,
   output logic                        mem_wr_en,
   output logic [$clog2(N)-1:0]        mem_wr_addr,
   output logic [(N+1)*GF_BIT-1:0]     mem_wr_data
);

   localparam int AW = $clog2(N);
   localparam int FW = $clog2(DRAIN);
   localparam int CW = (AW > FW) ? AW : FW;

`ifdef GAUSS_SINGULAR_CHECK_EN
   localparam bit SING_EN = 1'b1;
`else
   localparam bit SING_EN = 1'b0;
`endif

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_term_val;
   logic            cnt_term;
   logic            cnt_load;
   logic            cnt_en;
   logic            singular_q;

   // One counter serves rows and flush; it restarts from zero on every state change.
   assign cnt_term_val = (state == S_FLUSH) ? CW'(DRAIN - 1) : CW'(N - 1);
   assign cnt_load     = (state_nxt != state);
   assign cnt_en       = (state == S_FEED) || (state == S_FLUSH) || (state == S_COLLECT);

   gauss_seq_cnt #(.WIDTH(CW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val ('0),
      .en       (cnt_en),
      .term_val (cnt_term_val),
      .count    (cnt),
      .term     (cnt_term)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         singular_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && cmd_start) begin
            singular_q <= 1'b0;
         end else if (SING_EN && state == S_COLLECT && !pivot_ok) begin
            singular_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (cmd_start) state_nxt = S_READ;
         S_READ:    state_nxt = S_FEED;
         S_FEED:    if (cnt_term) state_nxt = S_FLUSH;
         S_FLUSH:   if (cnt_term) state_nxt = S_COLLECT;
         S_COLLECT: if (cnt_term) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Row 0 is requested in READ; FEED requests the next row while forwarding the current one.
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      mem_rd_en     = 1'b0;
      mem_rd_addr   = '0;
      arr_start     = 1'b0;
      arr_finish    = 1'b0;
      arr_functionA = 1'b0;
      arr_op        = OP_CODE_LEN'(OP_NOP);
      arr_data      = '0;
      mem_wr_en     = 1'b0;
      mem_wr_addr   = '0;
      mem_wr_data   = '0;
      case (state)
         S_READ: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
         end
         S_FEED: begin
            busy          = 1'b1;
            arr_data      = mem_rd_data;
            arr_op        = OP_CODE_LEN'(OP_GAUSS);
            arr_functionA = 1'b1;
            arr_start     = (cnt == '0);
            if (!cnt_term) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = AW'(cnt + 1'b1);
            end
         end
         S_FLUSH: begin
            busy          = 1'b1;
            arr_finish    = 1'b1;
            arr_functionA = 1'b1;
            arr_op        = OP_CODE_LEN'(OP_GAUSS);
         end
         S_COLLECT: begin
            busy        = 1'b1;
            arr_op      = OP_CODE_LEN'(OP_GAUSS);
            mem_wr_en   = 1'b1;
            mem_wr_addr = cnt[AW-1:0];
            mem_wr_data = arr_res_data;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign singular = singular_q;

endmodule
